// File: rtl/bounds_table_ctrl_if.sv
// Command and range-check handshake bundle between the monitoring command
// path (master) and the bounds buffer sequencing controller (slave).
interface bounds_table_ctrl_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_data_i;
    logic        chk_valid_i;
    logic [31:0] chk_addr_i;
    logic        chk_ready_o;
    logic        chk_resp_valid_o;
    logic        chk_hit_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_data_i, chk_valid_i, chk_addr_i,
        input  cmd_ready_o, chk_ready_o, chk_resp_valid_o, chk_hit_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_data_i, chk_valid_i, chk_addr_i,
        output cmd_ready_o, chk_ready_o, chk_resp_valid_o, chk_hit_o
    );
endinterface

// File: rtl/bounds_table_ctrl.sv
// Sequencing controller for the circular bounds buffer: turns SET_FIRST /
// SET_LAST / ABORT / CLEAR commands into validated single-cycle buffer writes
// and clears, and shares the buffer lookup port with a range-check requester,
// stalling checks while the buffer contents change.
module bounds_table_ctrl #(
    parameter int unsigned SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    bounds_table_ctrl_if.slave     bus_if,
    output logic                   buf_en_write_o,
    output logic [31:0]            buf_addr_first_o,
    output logic [31:0]            buf_addr_last_o,
    output logic                   buf_rst_us_o,
    output logic [31:0]            buf_find_addr_o,
    input  logic                   buf_addr_in_range_i,
    output logic [$clog2(SIZE):0]  count_o,
    output logic                   wrapped_o,
    output logic                   err_seq_o,
    output logic                   err_order_o
);
    localparam int unsigned CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] FULL = CW'(SIZE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_CLEAR  = 2'd3;

    localparam logic [1:0] OP_SET_FIRST = 2'd0;
    localparam logic [1:0] OP_SET_LAST  = 2'd1;
    localparam logic [1:0] OP_ABORT     = 2'd2;
    localparam logic [1:0] OP_CLEAR     = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   first_q, first_d;
    logic [31:0]   last_q, last_d;
    logic          err_seq_q, err_seq_d;
    logic          err_order_q, err_order_d;
    logic [CW-1:0] count_q;
    logic          wrapped_q;
    logic          chk_resp_q;
    logic          chk_hit_q;
    logic          ready_w;
    logic          cmd_fire;
    logic          chk_fire;

    // Both ports accept only while the buffer contents are stable.
    assign ready_w  = (state_q == S_IDLE) || (state_q == S_FIRST);
    assign cmd_fire = bus_if.cmd_valid_i && ready_w;
    assign chk_fire = bus_if.chk_valid_i && ready_w;

    assign bus_if.cmd_ready_o      = ready_w;
    assign bus_if.chk_ready_o      = ready_w;
    assign bus_if.chk_resp_valid_o = chk_resp_q;
    assign bus_if.chk_hit_o        = chk_hit_q;

    assign buf_en_write_o   = (state_q == S_COMMIT);
    assign buf_rst_us_o     = (state_q == S_CLEAR);
    assign buf_addr_first_o = first_q;
    assign buf_addr_last_o  = last_q;
    assign buf_find_addr_o  = bus_if.chk_addr_i;
    assign count_o          = count_q;
    assign wrapped_o        = wrapped_q;
    assign err_seq_o        = err_seq_q;
    assign err_order_o      = err_order_q;

    // Command sequencing: next state, operand registers and error pulses.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        err_seq_d   = 1'b0;
        err_order_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (bus_if.cmd_op_i)
                        OP_SET_FIRST: begin
                            first_d = bus_if.cmd_data_i;
                            state_d = S_FIRST;
                        end
                        OP_CLEAR: state_d = S_CLEAR;
                        default:  err_seq_d = 1'b1;
                    endcase
                end
            end
            S_FIRST: begin
                if (cmd_fire) begin
                    case (bus_if.cmd_op_i)
                        OP_SET_FIRST: first_d = bus_if.cmd_data_i;
                        OP_SET_LAST: begin
                            if (bus_if.cmd_data_i >= first_q) begin
                                last_d  = bus_if.cmd_data_i;
                                state_d = S_COMMIT;
                            end else begin
                                err_order_d = 1'b1;
                                state_d     = S_IDLE;
                            end
                        end
                        OP_ABORT: state_d = S_IDLE;
                        default:  state_d = S_CLEAR;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand and error-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            first_q     <= '0;
            last_q      <= '0;
            err_seq_q   <= 1'b0;
            err_order_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            last_q      <= last_d;
            err_seq_q   <= err_seq_d;
            err_order_q <= err_order_d;
        end
    end

    // Occupancy: saturates at SIZE, and a commit into a full buffer marks a wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (state_q == S_COMMIT) begin
            if (count_q == FULL) begin
                wrapped_q <= 1'b1;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    // Check response: register the lookup result of an accepted check.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_resp_q <= 1'b0;
            chk_hit_q  <= 1'b0;
        end else begin
            chk_resp_q <= chk_fire;
            if (chk_fire) begin
                chk_hit_q <= buf_addr_in_range_i;
            end
        end
    end
endmodule

// File: tb/tb_bounds_table_ctrl.sv
// Randomized self-checking bench for bounds_table_ctrl with a behavioural
// circular bounds buffer attached and a transaction-level reference model.
module tb_bounds_table_ctrl;
    localparam int unsigned SIZE = 8;
    localparam int unsigned CW   = $clog2(SIZE) + 1;
    localparam logic [1:0] SET_FIRST = 2'd0;
    localparam logic [1:0] SET_LAST  = 2'd1;
    localparam logic [1:0] ABORT     = 2'd2;
    localparam logic [1:0] CLEAR     = 2'd3;

    logic          clk;
    logic          rst_n;
    logic          buf_en_write;
    logic [31:0]   buf_addr_first;
    logic [31:0]   buf_addr_last;
    logic          buf_rst_us;
    logic [31:0]   buf_find_addr;
    logic          buf_addr_in_range;
    logic [CW-1:0] count;
    logic          wrapped;
    logic          err_seq;
    logic          err_order;

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    bounds_table_ctrl_if bus();

    bounds_table_ctrl #(.SIZE(SIZE)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .bus_if              (bus),
        .buf_en_write_o      (buf_en_write),
        .buf_addr_first_o    (buf_addr_first),
        .buf_addr_last_o     (buf_addr_last),
        .buf_rst_us_o        (buf_rst_us),
        .buf_find_addr_o     (buf_find_addr),
        .buf_addr_in_range_i (buf_addr_in_range),
        .count_o             (count),
        .wrapped_o           (wrapped),
        .err_seq_o           (err_seq),
        .err_order_o         (err_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached circular bounds buffer: oldest entry overwritten when full.
    logic [31:0] m_first [SIZE];
    logic [31:0] m_last  [SIZE];
    logic        m_vld   [SIZE];
    int unsigned m_wptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || buf_rst_us) begin
            for (int i = 0; i < SIZE; i++) m_vld[i] <= 1'b0;
            m_wptr <= 0;
        end else if (buf_en_write) begin
            m_first[m_wptr] <= buf_addr_first;
            m_last[m_wptr]  <= buf_addr_last;
            m_vld[m_wptr]   <= 1'b1;
            m_wptr          <= (m_wptr + 1) % SIZE;
        end
    end

    always_comb begin
        buf_addr_in_range = 1'b0;
        for (int i = 0; i < SIZE; i++)
            if (m_vld[i] && buf_find_addr >= m_first[i] && buf_find_addr <= m_last[i])
                buf_addr_in_range = 1'b1;
    end

    // Reference model: stored ranges (oldest first), pending first, wrap flag.
    logic [31:0] r_first_q[$];
    logic [31:0] r_last_q[$];
    bit          have_first;
    logic [31:0] ref_first;
    bit          ref_wrapped;

    function automatic bit ref_hit(input logic [31:0] a);
        for (int i = 0; i < r_first_q.size(); i++)
            if (a >= r_first_q[i] && a <= r_last_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void ref_push(input logic [31:0] f, input logic [31:0] l);
        if (r_first_q.size() == SIZE) begin
            ref_wrapped = 1'b1;
            void'(r_first_q.pop_front());
            void'(r_last_q.pop_front());
        end
        r_first_q.push_back(f);
        r_last_q.push_back(l);
    endfunction

    function automatic void ref_empty();
        r_first_q.delete();
        r_last_q.delete();
        ref_wrapped = 1'b0;
        have_first  = 1'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (!bus.cmd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_ready_wait", bus.cmd_ready_o, 1);
    endtask

    task automatic wait_chk_ready();
        int n = 0;
        while (!bus.chk_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("chk_ready_wait", bus.chk_ready_o, 1);
    endtask

    // Issue one command at a negedge, check its effects; returns at a negedge.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data);
        bit e_seq = 0, e_order = 0, e_write = 0, e_clear = 0;
        logic [31:0] e_first = ref_first;
        case (op)
            SET_FIRST: begin have_first = 1; ref_first = data; end
            SET_LAST: begin
                if (!have_first) e_seq = 1;
                else if (data >= ref_first) begin e_write = 1; ref_push(ref_first, data); end
                else e_order = 1;
                have_first = 0;
            end
            ABORT: begin
                if (!have_first) e_seq = 1;
                have_first = 0;
            end
            default: begin e_clear = 1; ref_empty(); end
        endcase
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_data_i  = data;
        wait_cmd_ready();
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check_eq("err_seq", err_seq, e_seq);
        check_eq("err_order", err_order, e_order);
        check_eq("buf_en_write", buf_en_write, e_write);
        check_eq("buf_rst_us", buf_rst_us, e_clear);
        if (e_write) begin
            check_eq("wr_first", buf_addr_first, e_first);
            check_eq("wr_last", buf_addr_last, data);
            check_eq("cmd_ready_commit", bus.cmd_ready_o, 0);
        end
        @(negedge clk);
        check_eq("pulses_quiet", {err_seq, err_order, buf_en_write, buf_rst_us}, 0);
        check_eq("count", count, r_first_q.size());
        check_eq("wrapped", wrapped, ref_wrapped);
    endtask

    // Issue one range check at a negedge; returns at a negedge.
    task automatic do_chk(input logic [31:0] addr);
        bit e_hit = ref_hit(addr);
        bus.chk_valid_i = 1'b1;
        bus.chk_addr_i  = addr;
        #1;
        check_eq("find_addr", buf_find_addr, addr);
        wait_chk_ready();
        @(negedge clk);
        bus.chk_valid_i = 1'b0;
        check_eq("resp_valid", bus.chk_resp_valid_o, 1);
        check_eq("chk_hit", bus.chk_hit_o, e_hit);
        @(negedge clk);
        check_eq("resp_idle", bus.chk_resp_valid_o, 0);
        check_eq("hit_hold", bus.chk_hit_o, e_hit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pre;
        bus.cmd_valid_i = 0; bus.cmd_op_i = 0; bus.cmd_data_i = 0;
        bus.chk_valid_i = 0; bus.chk_addr_i = 0;
        ref_empty();
        ref_first = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {buf_en_write, buf_rst_us, err_seq, err_order,
                 wrapped, bus.chk_hit_o, bus.chk_resp_valid_o}, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_first", buf_addr_first, 0);
        check_eq("rst_last", buf_addr_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {bus.cmd_ready_o, bus.chk_ready_o}, 2'b11);

        // Basic registration and boundary checks.
        do_cmd(SET_FIRST, 32'h1000);
        do_cmd(SET_LAST, 32'h10FF);
        do_chk(32'h10FF);
        do_chk(32'h1000);
        do_chk(32'h1100);
        do_chk(32'h0FFF);

        // Order error, one-address range, sequence errors.
        do_cmd(SET_FIRST, 32'h2000);
        do_cmd(SET_LAST, 32'h1FFF);
        do_cmd(SET_FIRST, 32'h2400);
        do_cmd(SET_LAST, 32'h2400);
        do_chk(32'h2400);
        do_chk(32'h2401);
        do_cmd(SET_LAST, 32'h3000);
        do_cmd(SET_FIRST, 32'h3000);
        do_cmd(ABORT, 32'h0);
        do_cmd(SET_LAST, 32'h3100);
        do_cmd(ABORT, 32'h0);

        // Clear with five stored ranges.
        do_cmd(CLEAR, 32'h0);
        for (int k = 0; k < 5; k++) begin
            do_cmd(SET_FIRST, 32'h4000 + 32'h100 * k);
            do_cmd(SET_LAST, 32'h40FF + 32'h100 * k);
        end
        do_cmd(CLEAR, 32'h0);
        do_chk(32'h4000);
        do_chk(32'h4480);

        // Wrap: SIZE+1 ranges, the first one gets overwritten.
        for (int k = 0; k <= SIZE; k++) begin
            do_cmd(SET_FIRST, 32'h8000 + 32'h100 * k);
            do_cmd(SET_LAST, 32'h8010 + 32'h100 * k);
        end
        do_chk(32'h8005);
        do_chk(32'h8000 + 32'h100 * SIZE);
        do_chk(32'h8110);

        // Stall: check held across SET_LAST sees pre-write then new contents.
        do_cmd(SET_FIRST, 32'h3000);
        pre = ref_hit(32'h3010);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = SET_LAST; bus.cmd_data_i = 32'h30FF;
        bus.chk_valid_i = 1'b1; bus.chk_addr_i = 32'h3010;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check_eq("stall_resp", bus.chk_resp_valid_o, 1);
        check_eq("stall_pre_hit", bus.chk_hit_o, pre);
        check_eq("stall_chk_ready", bus.chk_ready_o, 0);
        check_eq("stall_write", buf_en_write, 1);
        ref_push(32'h3000, 32'h30FF);
        have_first = 0;
        @(negedge clk);
        check_eq("stall_no_resp", bus.chk_resp_valid_o, 0);
        check_eq("stall_ready_back", bus.chk_ready_o, 1);
        @(negedge clk);
        bus.chk_valid_i = 1'b0;
        check_eq("stall_post_resp", bus.chk_resp_valid_o, 1);
        check_eq("stall_post_hit", bus.chk_hit_o, ref_hit(32'h3010));
        check_eq("stall_count", count, r_first_q.size());

        // Randomized command/check mix over a small address window.
        do_cmd(CLEAR, 32'h0);
        for (int it = 0; it < 300; it++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [31:0] d = 32'($urandom_range(0, 63)) << 4;
            if (r < 30)      do_cmd(SET_FIRST, d);
            else if (r < 60) do_cmd(SET_LAST, d | 32'($urandom_range(0, 15)));
            else if (r < 68) do_cmd(ABORT, 32'h0);
            else if (r < 71) do_cmd(CLEAR, 32'h0);
            else             do_chk(d | 32'($urandom_range(0, 15)));
        end

        // Reset during COMMIT drops the write.
        do_cmd(SET_FIRST, 32'h5000);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = SET_LAST; bus.cmd_data_i = 32'h50FF;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b0;
        ref_empty();
        #1;
        check_eq("mid_rst_write", buf_en_write, 0);
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_first", buf_addr_first, 0);
        check_eq("mid_rst_flags", {wrapped, err_seq, err_order, buf_rst_us,
                 bus.chk_hit_o, bus.chk_resp_valid_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", {bus.cmd_ready_o, bus.chk_ready_o}, 2'b11);
        do_chk(32'h5010);
        do_cmd(SET_LAST, 32'h5100);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
